// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with iterative multiply and registered CC.
// Single request in flight; valid/ready handshakes on both sides.
module alu_mc #(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int M     = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             mul_last;
    logic             cc_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_of;
    logic             alu_ill;

    assign mul_last = (state == MUL) && (cnt == CW'(STEPS - 1));
    assign is_sub   = (op == 3'd1);
    assign b_eff    = is_sub ? ~b : b;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; the release cycle is a bubble
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (op == 3'd4) ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle ops; SUB reuses the adder as a + ~b + 1
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        alu_ill = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                alu_res = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
                alu_of  = (a[M] == b_eff[M]) && (alu_res[M] != a[M]);
            end
            3'd2:    alu_res = a & b;
            3'd3:    alu_res = a ^ b;
            3'd4:    alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // One shift-add step over MUL_STEP multiplier bits
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplr[i]) acc_nxt = acc_nxt + (mcand << i);
        end
    end

    // Datapath, result and condition-code registers
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            illegal <= 1'b0;
            zf      <= 1'b1;
            sf      <= 1'b0;
            of      <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            cc_q    <= 1'b0;
        end else begin
            if (accept) begin
                cc_q  <= set_cc;
                mcand <= a;
                mplr  <= b;
                acc   <= '0;
                cnt   <= '0;
                if (op != 3'd4) begin
                    result  <= alu_res;
                    illegal <= alu_ill;
                    if (set_cc && !alu_ill) begin
                        zf <= (alu_res == '0);
                        sf <= alu_res[M];
                        of <= alu_of;
                    end
                end
            end
            if (state == MUL) begin
                acc   <= acc_nxt;
                mcand <= mcand << MUL_STEP;
                mplr  <= mplr >> MUL_STEP;
                cnt   <= cnt + CW'(1);
                if (mul_last) begin
                    result  <= acc_nxt;
                    illegal <= 1'b0;
                    if (cc_q) begin
                        zf <= (acc_nxt == '0);
                        sf <= acc_nxt[M];
                        of <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: 64-bit/4-step instance plus an
// 8-bit/2-step instance, scoreboard of expected completions.
module tb_alu_mc;

    typedef struct {
        logic [63:0] res;
        logic        ill;
        logic        zf;
        logic        sf;
        logic        vf;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        illegal;
    logic        zf;
    logic        sf;
    logic        of;

    logic        in_valid8;
    logic        in_ready8;
    logic [2:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        set_cc8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  result8;
    logic        illegal8;
    logic        zf8;
    logic        sf8;
    logic        of8;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic [10:0] sb8[$];
    logic ezf = 1'b1;
    logic esf = 1'b0;
    logic eof = 1'b0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(64), .MUL_STEP(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .set_cc(set_cc),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal),
        .zf(zf), .sf(sf), .of(of)
    );

    alu_mc #(.WIDTH(8), .MUL_STEP(2)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .set_cc(set_cc8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .illegal(illegal8),
        .zf(zf8), .sf(sf8), .of(of8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(logic [2:0] o, logic [63:0] x,
                                   logic [63:0] y);
        exp_t e;
        logic signed [64:0] s;
        e.res = '0;
        e.ill = 1'b0;
        e.vf  = 1'b0;
        e.lat = 1;
        e.zf  = 1'b0;
        e.sf  = 1'b0;
        case (o)
            3'd0: begin
                e.res = x + y;
                s = $signed({x[63], x}) + $signed({y[63], y});
                e.vf = (s[64] != s[63]);
            end
            3'd1: begin
                e.res = x - y;
                s = $signed({x[63], x}) - $signed({y[63], y});
                e.vf = (s[64] != s[63]);
            end
            3'd2: e.res = x & y;
            3'd3: e.res = x ^ y;
            3'd4: begin
                e.res = x * y;
                e.lat = 17;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic sc);
        exp_t e;
        int w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_ready got=0 want=1");
        end
        op = o;
        a = x;
        b = y;
        set_cc = sc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = o ^ 3'd1;
        a = ~x;
        b = ~y;
        set_cc = ~sc;
        e = model(o, x, y);
        if (sc && !e.ill) begin
            ezf = (e.res == 64'd0);
            esf = e.res[63];
            eof = e.vf;
        end
        e.zf = ezf;
        e.sf = esf;
        e.vf = eof;
        sb.push_back(e);
    endtask

    task automatic wait_out(output int lat, output bit ready_low);
        lat = 1;
        ready_low = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_low = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if ({in_ready, out_valid, result, illegal, zf, sf, of} !==
            {1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset64 got rdy=%b v=%b r=%h il=%b cc=%b%b%b want 1 0 0 0 100",
                     in_ready, out_valid, result, illegal, zf, sf, of);
        end
        n_tests++;
        if ({in_ready8, out_valid8, result8, zf8, sf8, of8} !==
            {1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset8 got rdy=%b v=%b r=%h cc=%b%b%b want 1 0 00 100",
                     in_ready8, out_valid8, result8, zf8, sf8, of8);
        end
    endtask

    task automatic test_op(input string nm, input logic [2:0] o,
                           input logic [63:0] x, input logic [63:0] y,
                           input logic sc);
        exp_t e;
        int lat;
        bit rl;
        issue(o, x, y, sc);
        wait_out(lat, rl);
        e = sb.pop_front();
        n_tests++;
        if ({out_valid, result, illegal, zf, sf, of} !==
            {1'b1, e.res, e.ill, e.zf, e.sf, e.vf}) begin
            n_fail++;
            $display("FAIL %s got v=%b r=%h il=%b cc=%b%b%b want 1 r=%h il=%b cc=%b%b%b",
                     nm, out_valid, result, illegal, zf, sf, of,
                     e.res, e.ill, e.zf, e.sf, e.vf);
        end
        n_tests++;
        if (lat !== e.lat || !rl) begin
            n_fail++;
            $display("FAIL %s_latency got lat=%0d rdy_low=%b want lat=%0d rdy_low=1",
                     nm, lat, rl, e.lat);
        end
        release_out();
    endtask

    task automatic test_add;
        test_add_body: begin
            test_op("add_ovf", 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        end
    endtask

    task automatic test_sub;
        test_op("sub_zero", 3'd1, 64'd5, 64'd5, 1'b1);
        test_op("sub_nocc", 3'd1, 64'd1, 64'd2, 1'b0);
    endtask

    task automatic test_mul;
        test_op("mul_neg", 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1);
        test_op("mul_big", 3'd4, 64'h0123_4567_89AB_CDEF,
                64'hFEDC_BA98_7654_3210, 1'b1);
    endtask

    task automatic test_illegal;
        test_op("illegal6", 3'd6, 64'd9, 64'd7, 1'b1);
    endtask

    task automatic test_reset_mid_mul;
        bit quiet = 1'b1;
        issue(3'd4, 64'd3, 64'd5, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        ezf = 1'b1;
        esf = 1'b0;
        eof = 1'b0;
        n_tests++;
        if ({out_valid, in_ready, zf, sf, of} !== 5'b01100) begin
            n_fail++;
            $display("FAIL mid_mul_reset got v=%b rdy=%b cc=%b%b%b want 0 1 100",
                     out_valid, in_ready, zf, sf, of);
        end
        for (int i = 0; i < 30; i++) begin
            if (out_valid) quiet = 1'b0;
            tick();
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL mid_mul_ghost got out_valid=1 want 0");
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int lat;
        bit rl;
        bit held = 1'b1;
        issue(3'd3, 64'hF0, 64'hFF, 1'b0);
        wait_out(lat, rl);
        e = sb.pop_front();
        n_tests++;
        if (result !== e.res || lat != 1) begin
            n_fail++;
            $display("FAIL bp_result got r=%h lat=%0d want r=%h lat=1",
                     result, lat, e.res);
        end
        op = 3'd0;
        a = 64'd1;
        b = 64'd1;
        set_cc = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || in_ready || result !== 64'h0F ||
                zf !== e.zf || illegal !== 1'b0) held = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (!held || !out_valid) begin
            n_fail++;
            $display("FAIL bp_hold got held=%b v=%b want 1 1", held, out_valid);
        end
        out_ready = 1'b1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_bubble got in_ready=%b want 0", in_ready);
        end
        tick();
        out_ready = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release got v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_width8_op(input string nm, input logic [2:0] o,
                                  input logic [7:0] x, input logic [7:0] y,
                                  input logic [10:0] exp_v, input int exp_lat);
        logic [10:0] ev;
        int lat = 1;
        op8 = o;
        a8 = x;
        b8 = y;
        set_cc8 = 1'b1;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        sb8.push_back(exp_v);
        while (!out_valid8 && lat < 50) begin
            tick();
            lat++;
        end
        ev = sb8.pop_front();
        n_tests++;
        if ({result8, zf8, sf8, of8} !== ev || lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s got r=%h cc=%b%b%b lat=%0d want r=%h cc=%b lat=%0d",
                     nm, result8, zf8, sf8, of8, lat, ev[10:3], ev[2:0], exp_lat);
        end
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    task automatic test_width8;
        test_width8_op("w8_add", 3'd0, 8'h80, 8'h80, {8'h00, 3'b101}, 1);
        test_width8_op("w8_mul", 3'd4, 8'h0F, 8'h11, {8'hFF, 3'b010}, 5);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            logic [2:0]  o;
            logic [63:0] x;
            logic [63:0] y;
            o = 3'($urandom_range(0, 7));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (i == 0) o = 3'd4;
            test_op($sformatf("b2b_%0d", i), o, x, y, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;
        set_cc = 1'b0;
        out_ready = 1'b0;
        in_valid8 = 1'b0;
        op8 = 3'd0;
        a8 = '0;
        b8 = '0;
        set_cc8 = 1'b0;
        out_ready8 = 1'b0;
        test_reset();
        test_add();
        test_reset_mid_mul();
        test_sub();
        test_mul();
        test_backpressure();
        test_illegal();
        test_width8();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
